// File: rtl/definitions_pkg.sv
// Shared definitions for the 3x3 window generator.
//   PIXEL_W     : greyscale pixel width
//   WINDOW_W    : packed 3x3 window width (9 pixels)
//   win_state_t : frame-tracking FSM states
package definitions_pkg;

    localparam int unsigned PIXEL_W  = 8;
    localparam int unsigned WINDOW_W = 9 * PIXEL_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2
    } win_state_t;

endpackage

// File: rtl/line_buffer.sv
// One image row of pixel storage with read-before-write at a single address.
//   clk        : rising-edge clock
//   wr_en_i    : write wr_data_i to addr_i on this edge
//   addr_i     : column address (read and write)
//   wr_data_i  : pixel to store
//   rd_data_o  : combinational read of addr_i (old value on a write cycle)
// Contents are intentionally not reset.
module line_buffer
    import definitions_pkg::*;
#(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               wr_en_i,
    input  logic [AW-1:0]      addr_i,
    input  logic [PIXEL_W-1:0] wr_data_i,
    output logic [PIXEL_W-1:0] rd_data_o
);

    logic [PIXEL_W-1:0] mem_q [DEPTH];

    // Row storage write port
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/window_gen_3x3.sv
// Streaming 3x3 neighbourhood generator over raster-order greyscale pixels.
//   clk              : rising-edge clock
//   rstN             : asynchronous active-low reset
//   pixel_in         : input pixel, raster order
//   pixel_in_valid   : pixel_in accepted this cycle
//   sof              : start of frame, marks pixel (0,0) when valid
//   window_out       : 3x3 window, byte i = kernel position i row-major (byte 0 oldest)
//   window_out_valid : one-cycle pulse per new window
//   frame_done       : pulse with the final window of an unaborted frame
//                      (only when WINDOW_FRAME_DONE_EN is defined)
module window_gen_3x3
    import definitions_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 640,
    parameter int unsigned IMG_HEIGHT = 480
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic [PIXEL_W-1:0]  pixel_in,
    input  logic                pixel_in_valid,
    input  logic                sof,
    output logic [WINDOW_W-1:0] window_out,
    output logic                window_out_valid
`ifdef WINDOW_FRAME_DONE_EN
    ,
    output logic                frame_done
`endif
);

    localparam int unsigned CW = $clog2(IMG_WIDTH);
    localparam int unsigned RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    win_state_t          state_q, state_d;
    logic [CW-1:0]       col_q, col_d, pos_col;
    logic [RW-1:0]       row_q, row_d, pos_row;
    logic [WINDOW_W-1:0] win_q, win_d;
    logic [WINDOW_W-1:0] window_out_q;
    logic                window_out_valid_q;
    logic                accept, emit, last_col, frame_end;
    logic [PIXEL_W-1:0]  lb0_rd, lb1_rd;

    // lb0 holds row r-1, lb1 holds row r-2; lb0's old value cascades into lb1
    line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb0 (
        .clk       (clk),
        .wr_en_i   (accept),
        .addr_i    (pos_col),
        .wr_data_i (pixel_in),
        .rd_data_o (lb0_rd)
    );

    line_buffer #(.DEPTH(IMG_WIDTH), .AW(CW)) u_lb1 (
        .clk       (clk),
        .wr_en_i   (accept),
        .addr_i    (pos_col),
        .wr_data_i (lb0_rd),
        .rd_data_o (lb1_rd)
    );

    // Position tracking, window shift and frame FSM
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        win_d     = win_q;
        accept    = 1'b0;
        emit      = 1'b0;
        last_col  = 1'b0;
        frame_end = 1'b0;
        pos_col   = col_q;
        pos_row   = row_q;

        // sof always restarts at (0,0), aborting any frame in progress
        if (sof) begin
            pos_col = '0;
            pos_row = '0;
        end

        accept = pixel_in_valid && (sof || (state_q != IDLE));

        if (accept) begin
            // Columns shift toward low bytes; new right column is {lb1, lb0, pixel}
            win_d = {pixel_in, win_q[71:56], lb0_rd, win_q[47:32], lb1_rd, win_q[23:8]};

            last_col  = (pos_col == COL_LAST);
            frame_end = last_col && (pos_row == ROW_LAST);
            emit      = (pos_row >= RW'(2)) && (pos_col >= CW'(2));

            if (last_col) begin
                col_d = '0;
                row_d = frame_end ? '0 : pos_row + RW'(1);
            end else begin
                col_d = pos_col + CW'(1);
                row_d = pos_row;
            end

            if (sof) begin
                state_d = FILL;
            end else begin
                unique case (state_q)
                    FILL:    if (last_col && (pos_row == RW'(1))) state_d = STREAM;
                    STREAM:  if (frame_end) state_d = IDLE;
                    default: state_d = state_q;
                endcase
            end
        end
    end

    // State, counters and window register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
        end
    end

    // Registered outputs; window_out holds between valid windows
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            window_out_q       <= '0;
            window_out_valid_q <= 1'b0;
        end else begin
            window_out_valid_q <= emit;
            if (emit) begin
                window_out_q <= win_d;
            end
        end
    end

    assign window_out       = window_out_q;
    assign window_out_valid = window_out_valid_q;

`ifdef WINDOW_FRAME_DONE_EN
    logic frame_done_q;

    // Final-window marker; an aborted frame never reaches its last pixel
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= emit && frame_end;
        end
    end

    assign frame_done = frame_done_q;
`endif

endmodule

// File: doc/window_gen_3x3.md
# window_gen_3x3

Streaming 3x3 neighbourhood generator that feeds the image-processing filters. It accepts one 8-bit greyscale pixel per valid cycle in raster order and buffers the two previous image rows. For every fully populated 3x3 neighbourhood it emits a 72-bit window with a one-cycle valid. The output is packed exactly as the gaussian/edge filters consume it, so those filters connect directly downstream.

## Interface
- IMG_WIDTH, 640, pixels per row (≥3)
- IMG_HEIGHT, 480, rows per frame (≥3)
- clk  in  1  rising-edge clock
- rstN  in  1  asynchronous active-low reset
- pixel_in  in  8  input pixel, raster order
- pixel_in_valid  in  1  pixel_in accepted this cycle
- sof  in  1  start of frame; qualified by pixel_in_valid, marks pixel (0,0)
- window_out  out  72  3x3 window; byte i = kernel position i, row-major (byte 0 top-left/oldest, byte 4 centre, byte 8 bottom-right/newest)
- window_out_valid  out  1  one-cycle pulse per new window
- frame_done  out  1  present only with WINDOW_FRAME_DONE_EN (see Configuration)

## Operation
- No backpressure; downstream is always ready. Gaps in pixel_in_valid freeze all state.
- Counters col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) give the position of each accepted pixel.
- Line buffers lb0 (row r-1) and lb1 (row r-2), IMG_WIDTH bytes each, indexed by col. Each accepted pixel p at column c does both updates on the same edge: lb1[c]<=lb0[c] and lb0[c]<=p.
- Window register: the three columns shift toward the low bytes. The new right column is {lb1[c], lb0[c], p}, with the values read before the line-buffer update.
- Window emitted when row≥2 and col≥2. It covers rows r-2..r and cols c-2..c, giving (W-2)×(H-2) windows per frame.
- FSM:
  - IDLE: pixels without sof are dropped. A pixel with sof is taken as (0,0) and the FSM moves to FILL.
  - FILL: rows 0–1, no windows. Moves to STREAM after pixel (1, W-1).
  - STREAM: after pixel (H-1, W-1) emits its window and returns to IDLE.
- sof during FILL or STREAM: the frame is aborted. That pixel becomes (0,0) and the FSM goes to FILL. The window from the previous pixel, already registered, still completes.
- Stale line-buffer contents are never emitted; the row≥2 gating guarantees this.

## Timing
- Reset values:
  - window_out = 0, window_out_valid = 0, frame_done = 0.
  - FSM = IDLE, col = row = 0.
  - Line buffers are not reset.
- Latency: window_out and window_out_valid are registered one cycle after the accepting edge of the pixel that completes the window.
- window_out holds its last value until the next valid window.
- At most one window per clock, so full throughput is one window per clock at 100% input duty.
- Reset mid-frame: everything clears immediately (asynchronous). The next frame requires sof.

## Configuration
- WINDOW_FRAME_DONE_EN:
  - Defined: adds output frame_done. It is a one-cycle pulse coincident with window_out_valid for the final window (H-1, W-1) of an unaborted frame.
  - Undefined: the port and its logic are absent.

## Structure
- definitions_pkg holds:
  - PIXEL_W=8 and WINDOW_W=72.
  - The FSM typedef enum {IDLE, FILL, STREAM} win_state_t.
- Sub-module line_buffer holds one IMG_WIDTH×8 row memory with read-before-write at address col. It is instantiated twice.

## Test plan
- W=4, H=4, pixel=16·r+c at full rate with sof on the first pixel → 4 windows. First window window_out = 0x222120121110020100, output one cycle after pixel (2,2). Last window = 0x333231232221131211.
- Same frame with pixel_in_valid toggling 1/0 → identical 4 windows in the same order. window_out_valid never lasts two consecutive cycles.
- Pixels without sof while IDLE, then a valid frame → no output from the dropped pixels; the frame output is identical to the first test.
- sof re-asserted at pixel (2,3) of frame A, followed by a full frame B → A's window (2,2) is still emitted. No windows come from A's remaining pixels; B yields exactly 4 correct windows.
- rstN pulsed low mid-STREAM → outputs go to 0 immediately. The subsequent full frame gives correct results.
- With WINDOW_FRAME_DONE_EN: frame_done pulses once, together with the 4th window. An aborted frame produces no frame_done.
